// File: rtl/seg7_pkg.sv
// Shared types and constants for the multi-digit 7-segment display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  // Glyph code per digit: 0-9 decimal digits, dash, minus (drawn as dash), blank.
  typedef logic [3:0] glyph_t;

  localparam glyph_t GLYPH_DASH  = 4'hA;
  localparam glyph_t GLYPH_MINUS = 4'hB;
  localparam glyph_t GLYPH_BLANK = 4'hF;

  // Raw segment patterns, active-high, bit0=a .. bit6=g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FORMAT
  } state_t;

  // 10^n as a 64-bit constant, used for the capture-time overflow limits.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_7seg_display_if.sv
// Request/result bundle between a value producer and the 7-segment display engine.
// Latency: n/a (wiring only).
// Backpressure: busy tells the master a request will be held as pending, not lost.
interface bin_to_7seg_display_if #(
  parameter int NUM_DIGITS = 6,
  parameter int IN_WIDTH   = 20
);
  logic [IN_WIDTH-1:0]     value;
  logic                    update;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [NUM_DIGITS*7-1:0] segs;

  modport master (output value, update, input busy, done, overflow, segs);
  modport slave  (input value, update, output busy, done, overflow, segs);
endinterface

// File: rtl/seg7_glyph.sv
// Glyph code to 7-segment pattern, with selectable output polarity.
// Latency: combinational.
// Backpressure: none; undefined codes render blank.
module seg7_glyph
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  glyph_t     code,
  output logic [6:0] seg
);

  logic [6:0] raw;

  // Look up the active-high pattern, then apply board polarity.
  always_comb begin
    raw = SEG_BLANK;
    case (code)
      4'd0:        raw = SEG_0;
      4'd1:        raw = SEG_1;
      4'd2:        raw = SEG_2;
      4'd3:        raw = SEG_3;
      4'd4:        raw = SEG_4;
      4'd5:        raw = SEG_5;
      4'd6:        raw = SEG_6;
      4'd7:        raw = SEG_7;
      4'd8:        raw = SEG_8;
      4'd9:        raw = SEG_9;
      GLYPH_DASH:  raw = SEG_DASH;
      GLYPH_MINUS: raw = SEG_DASH;
      default:     raw = SEG_BLANK;
    endcase
    seg = ACTIVE_LOW ? ~raw : raw;
  end

endmodule

// File: rtl/bin_to_7seg_display.sv
// Binary to multi-digit decimal 7-segment driver using a sequential double-dabble engine.
// Latency: done pulses IN_WIDTH+1 edges after the capturing edge (capture, IN_WIDTH shifts, format).
// Backpressure: updates while busy are held as one pending request (last value wins).
module bin_to_7seg_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int IN_WIDTH      = 20,
  parameter bit SIGNED_IN     = 1'b1,
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  bin_to_7seg_display_if.slave bus
);

  localparam int BW = NUM_DIGITS * 4;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0]       LAST_SHIFT = CW'(IN_WIDTH - 1);
  localparam logic [IN_WIDTH-1:0] ONE        = IN_WIDTH'(1);
  localparam logic [63:0]         MAX_POS    = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [63:0]         MAX_NEG    = pow10(NUM_DIGITS - 1) - 64'd1;
  localparam logic [6:0]          SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t                  state, state_nxt;
  logic [IN_WIDTH-1:0]     mag, pend_value, src, cap_mag;
  logic [BW-1:0]           bcd, bcd_adj;
  logic [CW-1:0]           cnt;
  logic                    neg, ovf, pending, done_q, ovf_q;
  logic                    start, cap_neg, cap_ovf;
  logic [NUM_DIGITS*7-1:0] segs_q, seg_enc;
  glyph_t                  glyph [NUM_DIGITS];
  int                      msd;

  // Start whenever idle with a fresh or pending request; a live update is newer than pending.
  always_comb begin
    start   = (state == ST_IDLE) && (bus.update || pending);
    src     = bus.update ? bus.value : pend_value;
    cap_neg = SIGNED_IN && src[IN_WIDTH-1];
    cap_mag = cap_neg ? (~src + ONE) : src;
    cap_ovf = 64'(cap_mag) > (cap_neg ? MAX_NEG : MAX_POS);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> SHIFT (IN_WIDTH cycles) -> FORMAT -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (cnt == LAST_SHIFT) state_nxt = ST_FORMAT;
      ST_FORMAT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Double-dabble correction: bump every nibble >= 5 by 3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // Glyph selection: overflow dashes, leading-zero blanking and minus placement.
  always_comb begin
    msd = 0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd[4*d +: 4] != 4'd0) msd = d;
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      glyph[d] = GLYPH_BLANK;
      if (ovf)                       glyph[d] = GLYPH_DASH;
      else if (!BLANK_LEADING)       glyph[d] = (neg && d == NUM_DIGITS - 1) ? GLYPH_MINUS : bcd[4*d +: 4];
      else if (d <= msd)             glyph[d] = bcd[4*d +: 4];
      else if (neg && d == msd + 1)  glyph[d] = GLYPH_MINUS;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_glyph #(.ACTIVE_LOW(ACTIVE_LOW)) u_glyph (
      .code (glyph[g]),
      .seg  (seg_enc[7*g +: 7])
    );
  end

  // Datapath: capture, pending tracking, shifting, and the registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag        <= '0;
      pend_value <= '0;
      bcd        <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      ovf        <= 1'b0;
      pending    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      segs_q     <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      done_q <= (state == ST_FORMAT);
      if (start) begin
        mag     <= cap_mag;
        neg     <= cap_neg;
        ovf     <= cap_ovf;
        bcd     <= '0;
        cnt     <= '0;
        pending <= 1'b0;
      end else if (bus.update) begin
        pending    <= 1'b1;
        pend_value <= bus.value;
      end
      if (state == ST_SHIFT) begin
        bcd <= BW'({bcd_adj, mag[IN_WIDTH-1]});
        mag <= {mag[IN_WIDTH-2:0], 1'b0};
        cnt <= cnt + CW'(1);
      end
      if (state == ST_FORMAT) begin
        segs_q <= seg_enc;
        ovf_q  <= ovf;
      end
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.segs     = segs_q;

endmodule

// File: tb/tb_bin_to_7seg_display.sv
// Scoreboard bench for bin_to_7seg_display: default instance plus a no-blanking instance.
// Expected patterns come from an integer decimal model pushed when each update is driven.
// Done pulses pop the scoreboard and compare segs/overflow.
module tb_bin_to_7seg_display;

  typedef struct packed {
    logic [41:0] segs;
    logic        ovf;
  } exp_t;

  localparam logic [41:0] ALL_BLANK = {42{1'b1}};

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   done_m = 0;
  int   done_n = 0;
  int   lat;
  int   d0;
  logic [41:0] last_m = ALL_BLANK;
  logic [41:0] last_n = ALL_BLANK;
  exp_t q_m[$];
  exp_t q_n[$];

  always #5 clk = ~clk;

  bin_to_7seg_display_if #(.NUM_DIGITS(6), .IN_WIDTH(20)) m_if ();
  bin_to_7seg_display_if #(.NUM_DIGITS(6), .IN_WIDTH(20)) n_if ();

  bin_to_7seg_display dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if)
  );

  bin_to_7seg_display #(.BLANK_LEADING(1'b0)) dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (n_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Active-low encoding of glyph g: 0-9 digits, 10 dash, anything else blank.
  function automatic logic [6:0] enc(input int g);
    logic [6:0] raw;
    case (g)
      0: raw = 7'h3F;  1: raw = 7'h06;  2: raw = 7'h5B;  3: raw = 7'h4F;
      4: raw = 7'h66;  5: raw = 7'h6D;  6: raw = 7'h7D;  7: raw = 7'h07;
      8: raw = 7'h7F;  9: raw = 7'h6F;  10: raw = 7'h40;
      default: raw = 7'h00;
    endcase
    return ~raw;
  endfunction

  function automatic exp_t model(input int v, input bit blank);
    exp_t e;
    bit   neg;
    int   mag, tmp, nd, g;
    int   digs [6];
    neg   = (v < 0);
    mag   = neg ? -v : v;
    e.ovf = neg ? (mag > 99999) : (mag > 999999);
    tmp = mag;
    nd  = 1;
    for (int i = 0; i < 6; i++) begin
      digs[i] = tmp % 10;
      tmp     = tmp / 10;
      if (digs[i] != 0) nd = i + 1;
    end
    for (int d = 0; d < 6; d++) begin
      if (e.ovf)       g = 10;
      else if (!blank) g = (neg && d == 5) ? 10 : digs[d];
      else if (d < nd) g = digs[d];
      else if (neg && d == nd) g = 10;
      else             g = 11;
      e.segs[7*d +: 7] = enc(g);
    end
    return e;
  endfunction

  // Scoreboard for the default instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && m_if.done) begin
      done_m++;
      chk("m_busy_at_done", m_if.busy, 0);
      chk("m_sb_nonempty", q_m.size() != 0, 1);
      if (q_m.size() != 0) begin
        e = q_m.pop_front();
        chk("m_segs", m_if.segs, e.segs);
        chk("m_ovf", m_if.overflow, e.ovf);
      end
      last_m = m_if.segs;
    end
  end

  // Scoreboard for the no-blanking instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && n_if.done) begin
      done_n++;
      chk("n_sb_nonempty", q_n.size() != 0, 1);
      if (q_n.size() != 0) begin
        e = q_n.pop_front();
        chk("n_segs", n_if.segs, e.segs);
        chk("n_ovf", n_if.overflow, e.ovf);
      end
      last_n = n_if.segs;
    end
  end

  // One-cycle update on the chosen instance; lat = edges from driving update to done.
  task automatic send(input bit sel, input int v, output int l);
    logic d;
    if (sel) begin
      n_if.value = v[19:0]; n_if.update = 1'b1; q_n.push_back(model(v, 1'b0));
    end else begin
      m_if.value = v[19:0]; m_if.update = 1'b1; q_m.push_back(model(v, 1'b1));
    end
    l = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        m_if.update = 1'b0;
        n_if.update = 1'b0;
        chk("busy_after_capture", sel ? n_if.busy : m_if.busy, 1);
      end
      if (i == 10) chk("segs_hold", sel ? n_if.segs : m_if.segs, sel ? last_n : last_m);
      d = sel ? n_if.done : m_if.done;
      if (d) begin
        l = i;
        break;
      end
    end
    chk("latency", l, 22);
  endtask

  initial begin
    reset = 1'b1;
    m_if.value = '0; m_if.update = 1'b0;
    n_if.value = '0; n_if.update = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", m_if.busy, 0);
    chk("rst_done", m_if.done, 0);
    chk("rst_ovf", m_if.overflow, 0);
    chk("rst_segs", m_if.segs, ALL_BLANK);
    chk("rst_n_segs", n_if.segs, ALL_BLANK);

    // Plain values, negatives, zero and the representable extremes.
    send(1'b0, 12345, lat);
    send(1'b0, -42, lat);
    send(1'b0, 0, lat);
    send(1'b0, 524287, lat);
    send(1'b0, -524288, lat);
    send(1'b0, -99999, lat);
    send(1'b0, -100000, lat);
    send(1'b0, 7, lat);

    // No leading-zero blanking: zeros shown, minus in the top digit.
    send(1'b1, 42, lat);
    send(1'b1, -42, lat);
    send(1'b1, 0, lat);

    // Updates while busy: 5 shown, 7 dropped, 9 shown; exactly two dones.
    d0 = done_m;
    m_if.value = 20'd5; m_if.update = 1'b1; q_m.push_back(model(5, 1'b1));
    @(posedge clk); #1;
    m_if.value = 20'd7;
    @(posedge clk); #1;
    m_if.value = 20'd9; q_m.push_back(model(9, 1'b1));
    @(posedge clk); #1;
    m_if.update = 1'b0;
    for (int i = 0; i < 80 && done_m < d0 + 2; i++) @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    chk("pending_done_count", done_m - d0, 2);
    chk("pending_sb_drained", q_m.size(), 0);

    // Reset mid-conversion, with an update on the reset edge: aborted, nothing shown.
    m_if.value = 20'd123; m_if.update = 1'b1;
    @(posedge clk); #1;
    m_if.update = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1; m_if.value = 20'd77; m_if.update = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; m_if.update = 1'b0;
    last_m = ALL_BLANK;
    d0 = done_m;
    chk("abort_busy", m_if.busy, 0);
    chk("abort_segs", m_if.segs, ALL_BLANK);
    chk("abort_ovf", m_if.overflow, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_done", done_m - d0, 0);
    send(1'b0, 8, lat);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
